// File: rtl/key_pkg.sv
// Shared definitions for the push-button debouncer.
// Holds the per-key FSM encoding and the debounce length constants.
package key_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT_DN = 2'd1,
        PRESSED = 2'd2,
        FILT_UP = 2'd3
    } key_fsm_t;

    // 20 ms at 50 MHz
    localparam int DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int SIM_DEBOUNCE_CYC = 16;

endpackage

// File: rtl/key_debounce_chan.sv
// Single-key debounce channel: 2-flop synchroniser, filter FSM and counter.
// Ports: clk, rst_n, key_in (raw, active-low), key_state, key_press,
// key_release (registered), press_nxt (combinational next key_press).
module key_debounce_chan
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic press_nxt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             sync2;
    key_fsm_t         st;
    key_fsm_t         st_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             state_nxt;
    logic             rel_nxt;

    always_comb begin
        st_nxt    = st;
        cnt_nxt   = cnt;
        press_nxt = 1'b0;
        rel_nxt   = 1'b0;
        state_nxt = key_state;
        unique case (st)
            IDLE: begin
                if (!sync2) begin
                    st_nxt  = FILT_DN;
                    cnt_nxt = '0;
                end
            end
            FILT_DN: begin
                if (sync2) begin
                    st_nxt  = IDLE;
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    st_nxt    = PRESSED;
                    cnt_nxt   = '0;
                    press_nxt = 1'b1;
                    state_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (sync2) begin
                    st_nxt  = FILT_UP;
                    cnt_nxt = '0;
                end
            end
            FILT_UP: begin
                if (!sync2) begin
                    st_nxt  = PRESSED;
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    st_nxt    = IDLE;
                    cnt_nxt   = '0;
                    rel_nxt   = 1'b1;
                    state_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                st_nxt  = IDLE;
                cnt_nxt = '0;
            end
        endcase
    end

    // Synchroniser resets to "released" so a reset never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            st          <= IDLE;
            cnt         <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            sync1       <= key_in;
            sync2       <= sync1;
            st          <= st_nxt;
            cnt         <= cnt_nxt;
            key_state   <= state_nxt;
            key_press   <= press_nxt;
            key_release <= rel_nxt;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Multi-key debouncer with press/release events and lowest-key encoder.
// Ports: clk, rst_n, key_in[KEY_W], key_state, key_press, key_release,
// key_valid, key_code[3].
module key_debounce
    import key_pkg::*;
#(
    parameter int KEY_W        = 4,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_state,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic             key_valid,
    output logic [2:0]       key_code
);

    logic [KEY_W-1:0] press_nxt;
    logic [2:0]       code_nxt;

    for (genvar i = 0; i < KEY_W; i++) begin : g_chan
        key_debounce_chan #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .key_in     (key_in[i]),
            .key_state  (key_state[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .press_nxt  (press_nxt[i])
        );
    end

    // Scan high to low so the lowest set index wins
    always_comb begin
        code_nxt = 3'd0;
        for (int k = KEY_W - 1; k >= 0; k--) begin
            if (press_nxt[k]) code_nxt = 3'(k);
        end
    end

    // Registered from press_nxt so it lines up with key_press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_valid <= 1'b0;
            key_code  <= 3'd0;
        end else begin
            key_valid <= |press_nxt;
            if (|press_nxt) key_code <= code_nxt;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a short debounce length.
// Expected events are queued at stimulus time and matched by a monitor.
module tb_key_debounce;
    import key_pkg::*;

    localparam int D   = SIM_DEBOUNCE_CYC;
    localparam int LAT = D + 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_in = 4'hF;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       key_valid;
    logic [2:0] key_code;

    typedef struct {
        string      tag;
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] state;
        logic       valid;
        logic [2:0] code;
    } ev_t;

    ev_t sb[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;
    logic [2:0] mcode = 3'd0;

    key_debounce #(
        .KEY_W       (4),
        .DEBOUNCE_CYC(D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_valid  (key_valid),
        .key_code   (key_code)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input string tag, input logic [3:0] p,
                        input logic [3:0] r, input logic [3:0] s,
                        input logic [2:0] c);
        ev_t e;
        e.tag   = tag;
        e.cyc   = cyc + LAT;
        e.press = p;
        e.rel   = r;
        e.state = s;
        e.valid = (p != 4'd0);
        e.code  = c;
        sb.push_back(e);
    endtask

    task automatic quiet(input string tag, input logic [3:0] s,
                         input logic [2:0] c);
        chk({tag, "_state"}, int'(key_state), int'(s));
        chk({tag, "_code"}, int'(key_code), int'(c));
        chk({tag, "_pulses"},
            int'({key_press, key_release, key_valid}), 0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) mcode = 3'd0;
            if (key_press != 4'd0 || key_release != 4'd0 || key_valid) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_event cyc=%0d press=%b rel=%b valid=%b exp=none",
                           cyc, key_press, key_release, key_valid);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    if (e.valid) mcode = e.code;
                    chk({e.tag, "_cyc"}, cyc, e.cyc);
                    chk({e.tag, "_press"}, int'(key_press), int'(e.press));
                    chk({e.tag, "_rel"}, int'(key_release), int'(e.rel));
                    chk({e.tag, "_valid"}, int'(key_valid), int'(e.valid));
                    chk({e.tag, "_code"}, int'(key_code), int'(mcode));
                    chk({e.tag, "_state"}, int'(key_state), int'(e.state));
                end
            end
        end
    end

    initial begin
        // Reset with all keys released
        tick(3);
        quiet("rst", 4'b0000, 3'd0);
        rst_n = 1'b1;
        tick(100);
        quiet("idle100", 4'b0000, 3'd0);

        // Clean press and release of key 1
        push("press1", 4'b0010, 4'b0000, 4'b0010, 3'd1);
        key_in[1] = 1'b0;
        tick(40);
        quiet("hold1", 4'b0010, 3'd1);
        push("rel1", 4'b0000, 4'b0010, 4'b0000, 3'd1);
        key_in[1] = 1'b1;
        tick(40);
        quiet("up1", 4'b0000, 3'd1);

        // Bouncing key 0, ending high: no event
        for (int i = 0; i < 12; i++) begin
            key_in[0] = i[0];
            tick(5);
        end
        key_in[0] = 1'b1;
        tick(40);
        quiet("bounce_hi", 4'b0000, 3'd1);

        // Bouncing then steady low: one press from the last fall
        for (int i = 0; i < 12; i++) begin
            key_in[0] = i[0];
            tick(5);
        end
        push("press0_b", 4'b0001, 4'b0000, 4'b0001, 3'd0);
        key_in[0] = 1'b0;
        tick(40);
        quiet("bounce_lo", 4'b0001, 3'd0);
        push("rel0_b", 4'b0000, 4'b0001, 4'b0000, 3'd0);
        key_in[0] = 1'b1;
        tick(40);

        // Simultaneous press of keys 3 and 2
        push("press32", 4'b1100, 4'b0000, 4'b1100, 3'd2);
        key_in[3:2] = 2'b00;
        tick(40);
        quiet("hold32", 4'b1100, 3'd2);
        push("rel32", 4'b0000, 4'b1100, 4'b0000, 3'd2);
        key_in[3:2] = 2'b11;
        tick(40);
        quiet("up32", 4'b0000, 3'd2);

        // Reset while key 0 is held
        push("press0_r", 4'b0001, 4'b0000, 4'b0001, 3'd0);
        key_in[0] = 1'b0;
        tick(30);
        quiet("pre_rst", 4'b0001, 3'd0);
        rst_n = 1'b0;
        #1;
        quiet("mid_rst", 4'b0000, 3'd0);
        tick(2);
        rst_n = 1'b1;
        push("press0_a", 4'b0001, 4'b0000, 4'b0001, 3'd0);
        tick(40);
        quiet("post_rst", 4'b0001, 3'd0);
        push("rel0_a", 4'b0000, 4'b0001, 4'b0000, 3'd0);
        key_in[0] = 1'b1;
        tick(40);

        // Glitch on key 2: 15 low cycles rejected
        key_in[2] = 1'b0;
        tick(15);
        key_in[2] = 1'b1;
        tick(40);
        quiet("glitch15", 4'b0000, 3'd0);

        // Shortest low pulse that is accepted, then a normal release
        push("press2_g", 4'b0100, 4'b0000, 4'b0100, 3'd2);
        key_in[2] = 1'b0;
        tick(D + 1);
        push("rel2_g", 4'b0000, 4'b0100, 4'b0000, 3'd2);
        key_in[2] = 1'b1;
        tick(50);
        quiet("glitch_ok", 4'b0000, 3'd2);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
